fp_add_arbiter: RTL

FP_ADD_ARBITER -- requirements
Module: fp_add_arbiter

---
 rtl/fp_add_arbiter_pkg.sv | 15 +
 rtl/fp_add_arbiter_rr_pick.sv | 28 ++
 rtl/fp_add_arbiter.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/fp_add_arbiter_pkg.sv
// Shared widths and controller state encoding for the custom-float adder
// and the arbiter that time-shares it.
package fp_add_arbiter_pkg;

    localparam int MANTISSA   = 11;
    localparam int EXPONENT   = 5;
    localparam int DATA_WIDTH = MANTISSA + EXPONENT;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2
    } ctrl_state_t;

endpackage

// File: rtl/fp_add_arbiter_rr_pick.sv
// Round-robin picker: the search starts one past the last granted
// requester, wraps modulo NREQ, and grants the first asserted request.
module rr_pick #(
    parameter int NREQ = 4,
    localparam int ID_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] last_grant,
    output logic [NREQ-1:0] grant
);

    logic found;

    // Rotating priority search producing a one-hot grant.
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int off = 1; off <= NREQ; off++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!found && req[i] && (i == (int'(last_grant) + off) % NREQ)) begin
                    grant[i] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fp_add_arbiter.sv
// Shares one external combinational custom-float adder among NREQ
// requesters through a two-stage pipeline (issue -> result) with a
// round-robin accept and a ready/valid result handshake.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | issue and result stages both empty
// ST_RUN   | work in flight; result free or draining this cycle
// ST_STALL | issue and result both full, consumer not taking the result
module fp_add_arbiter #(
    parameter int NREQ     = 4,
    parameter int MANTISSA = fp_add_arbiter_pkg::MANTISSA,
    parameter int EXPONENT = fp_add_arbiter_pkg::EXPONENT,
    localparam int DATA_WIDTH = MANTISSA + EXPONENT,
    localparam int ID_W       = $clog2(NREQ)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  logic [NREQ*DATA_WIDTH-1:0] req_a,
    input  logic [NREQ*DATA_WIDTH-1:0] req_b,
    output logic [DATA_WIDTH-1:0]      add_a,
    output logic [DATA_WIDTH-1:0]      add_b,
    input  logic [MANTISSA-1:0]        add_m,
    input  logic [EXPONENT-1:0]        add_ex,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [DATA_WIDTH-1:0]      rsp_data,
    output logic [ID_W-1:0]            rsp_id,
    output logic                       busy
);

    import fp_add_arbiter_pkg::*;

    ctrl_state_t     state;
    logic            ready_en;
    logic            iss_valid;
    logic [ID_W-1:0] iss_id;
    logic            res_valid;
    logic [ID_W-1:0] last_grant;
    logic [NREQ-1:0] grant;
    logic [ID_W-1:0] grant_id;
    logic            advance;
    logic            can_accept;
    logic            accept;
    logic            iss_next;
    logic            res_next;

    rr_pick #(.NREQ(NREQ)) u_rr_pick (
        .req        (req_valid),
        .last_grant (last_grant),
        .grant      (grant)
    );

    // One-hot grant to requester index for the operand mux and id tag.
    always_comb begin
        grant_id = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) grant_id = ID_W'(i);
        end
    end

    // ready_en keeps req_ready low while reset is asserted without routing
    // rst_n into the combinational accept path.
    assign advance    = iss_valid & (~res_valid | rsp_ready);
    assign can_accept = ready_en & (~iss_valid | advance);
    assign req_ready  = can_accept ? grant : '0;
    assign accept     = |(req_valid & req_ready);
    assign iss_next   = accept | (iss_valid & ~advance);
    assign res_next   = advance | (res_valid & ~rsp_ready);
    assign rsp_valid  = res_valid;
    assign busy       = (state != ST_IDLE);

    // Accept gate opens on the first clock after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ready_en <= 1'b0;
        else        ready_en <= 1'b1;
    end

    // Issue stage: captures the granted operands, holds them while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iss_valid <= 1'b0;
            iss_id    <= '0;
            add_a     <= '0;
            add_b     <= '0;
        end else begin
            iss_valid <= iss_next;
            if (accept) begin
                iss_id <= grant_id;
                add_a  <= req_a[grant_id*DATA_WIDTH +: DATA_WIDTH];
                add_b  <= req_b[grant_id*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Result stage: samples the adder output when the issue stage advances.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
        end else begin
            res_valid <= res_next;
            if (advance) begin
                rsp_data <= {add_m, add_ex};
                rsp_id   <= iss_id;
            end
        end
    end

    // Round-robin pointer moves only on a completed handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      last_grant <= ID_W'(NREQ - 1);
        else if (accept) last_grant <= grant_id;
    end

    // Controller state tracking pipeline occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) state <= ST_RUN;
                end
                ST_RUN: begin
                    if (iss_valid && res_valid && !rsp_ready) state <= ST_STALL;
                    else if (!iss_next && !res_next)          state <= ST_IDLE;
                end
                ST_STALL: begin
                    if (rsp_ready) state <= ST_RUN;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
